// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: loop-nest index and address generator for C[i][j] += A[i][k]*B[k][j].
// Walks i-outer, j-middle, k-inner and presents one tuple per handshake.
// Addresses are built with incremental adds only. The add strides come from the
// dimensions latched when the run starts.
//
// state | meaning
// IDLE  | waiting for start; dims and bases sampled on an accepted start
// RUN   | tuple on the outputs, advances on each out_valid && out_ready
// DONE  | one-cycle done pulse after the final tuple, then back to IDLE
module matmul_addr_gen #(
  parameter int IDX_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_i,
  input  logic [IDX_W-1:0]  num_j,
  input  logic [IDX_W-1:0]  num_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  idx_i,
  output logic [IDX_W-1:0]  idx_j,
  output logic [IDX_W-1:0]  idx_k,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic              first_k,
  output logic              last_k,
  output logic              busy,
  output logic              done,
  output logic              err_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0]  ONE_I = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t             state;
  logic [IDX_W-1:0]   n_i, n_j, n_k;
  logic [ADDR_W-1:0]  base_b_q;
  logic [ADDR_W-1:0]  row_a;   // address of A[i][0]
  logic [ADDR_W-1:0]  col_b;   // address of B[0][j]

  logic               i_max, j_max, k_max;
  logic [ADDR_W-1:0]  n_j_ext, n_k_ext;

  // Loop-end detection and zero-extended strides
  always_comb begin
    i_max   = (idx_i == n_i - ONE_I);
    j_max   = (idx_j == n_j - ONE_I);
    k_max   = (idx_k == n_k - ONE_I);
    n_j_ext = ADDR_W'(n_j);
    n_k_ext = ADDR_W'(n_k);
  end

  // Accumulator flags follow the registered k index; latched n_k of 0 after reset keeps last_k low
  assign first_k = (idx_k == '0);
  assign last_k  = k_max;

  // Controller: start/latch, handshake-driven advance, done and error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_i       <= '0;
      n_j       <= '0;
      n_k       <= '0;
      base_b_q  <= '0;
      row_a     <= '0;
      col_b     <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      idx_k     <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_c    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_i == '0 || num_j == '0 || num_k == '0) begin
              err_zero <= 1'b1;
            end else begin
              n_i       <= num_i;
              n_j       <= num_j;
              n_k       <= num_k;
              base_b_q  <= base_b;
              row_a     <= base_a;
              col_b     <= base_b;
              idx_i     <= '0;
              idx_j     <= '0;
              idx_k     <= '0;
              addr_a    <= base_a;
              addr_b    <= base_b;
              addr_c    <= base_c;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            if (!k_max) begin
              idx_k  <= idx_k + ONE_I;
              addr_a <= addr_a + ONE_A;
              addr_b <= addr_b + n_j_ext;
            end else if (!j_max) begin
              idx_k  <= '0;
              idx_j  <= idx_j + ONE_I;
              addr_a <= row_a;
              col_b  <= col_b + ONE_A;
              addr_b <= col_b + ONE_A;
              addr_c <= addr_c + ONE_A;
            end else if (!i_max) begin
              idx_k  <= '0;
              idx_j  <= '0;
              idx_i  <= idx_i + ONE_I;
              row_a  <= row_a + n_k_ext;
              addr_a <= row_a + n_k_ext;
              col_b  <= base_b_q;
              addr_b <= base_b_q;
              addr_c <= addr_c + ONE_A;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Testbench for matmul_addr_gen: scoreboard of expected tuples built from a
// multiply-based reference model, popped by a monitor on each handshake.
module tb_matmul_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_i, num_j, num_k;
  logic [31:0] base_a, base_b, base_c;
  logic        out_valid, out_ready;
  logic [31:0] idx_i, idx_j, idx_k;
  logic [31:0] addr_a, addr_b, addr_c;
  logic        first_k, last_k, busy, done, err_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] i, j, k, a, b, c;
    logic        fk, lk;
  } exp_t;

  exp_t sb[$];

  matmul_addr_gen #(.IDX_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_i(num_i), .num_j(num_j), .num_k(num_k),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .first_k(first_k), .last_k(last_k),
    .busy(busy), .done(done), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  // Drive a start request and, if it should be accepted, queue the reference tuples
  task automatic drive_start(input int ni, input int nj, input int nk,
                             input logic [31:0] ba, input logic [31:0] bb,
                             input logic [31:0] bc, input bit push);
    exp_t e;
    start = 1'b1;
    num_i = ni; num_j = nj; num_k = nk;
    base_a = ba; base_b = bb; base_c = bc;
    if (push) begin
      for (int i = 0; i < ni; i++)
        for (int j = 0; j < nj; j++)
          for (int k = 0; k < nk; k++) begin
            e.i = i; e.j = j; e.k = k;
            e.a = ba + 32'(i * nk + k);
            e.b = bb + 32'(k * nj + j);
            e.c = bc + 32'(i * nj + j);
            e.fk = (k == 0);
            e.lk = (k == nk - 1);
            sb.push_back(e);
          end
    end
  endtask

  // Monitor: compare each accepted tuple with the scoreboard and check holding under backpressure
  logic        p_valid, p_ready;
  logic [31:0] p_i, p_j, p_k, p_a, p_b, p_c;
  initial p_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (p_valid && !p_ready && out_valid) begin
        checks++;
        if ({idx_i, idx_j, idx_k, addr_a, addr_b, addr_c} !== {p_i, p_j, p_k, p_a, p_b, p_c}) begin
          failures++;
          $display("FAIL hold: got (%0d,%0d,%0d) a=%h b=%h c=%h, required (%0d,%0d,%0d) a=%h b=%h c=%h",
                   idx_i, idx_j, idx_k, addr_a, addr_b, addr_c, p_i, p_j, p_k, p_a, p_b, p_c);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_tuple: got (%0d,%0d,%0d), required no tuple", idx_i, idx_j, idx_k);
        end else begin
          e = sb.pop_front();
          if ({idx_i, idx_j, idx_k, addr_a, addr_b, addr_c, first_k, last_k} !==
              {e.i, e.j, e.k, e.a, e.b, e.c, e.fk, e.lk}) begin
            failures++;
            $display("FAIL tuple: got (%0d,%0d,%0d) a=%h b=%h c=%h f=%b l=%b, required (%0d,%0d,%0d) a=%h b=%h c=%h f=%b l=%b",
                     idx_i, idx_j, idx_k, addr_a, addr_b, addr_c, first_k, last_k,
                     e.i, e.j, e.k, e.a, e.b, e.c, e.fk, e.lk);
          end
        end
      end
    end
    p_valid = out_valid; p_ready = out_ready;
    p_i = idx_i; p_j = idx_j; p_k = idx_k; p_a = addr_a; p_b = addr_b; p_c = addr_c;
  end

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    num_i = 0; num_j = 0; num_k = 0; base_a = 0; base_b = 0; base_c = 0;
    #12;
    checks++;
    if ({out_valid, busy, done, err_zero, first_k, last_k} !== 6'b000010) begin
      failures++;
      $display("FAIL reset_flags: got v=%b busy=%b done=%b err=%b f=%b l=%b, required 0 0 0 0 1 0",
               out_valid, busy, done, err_zero, first_k, last_k);
    end
    checks++;
    if ({idx_i, idx_j, idx_k, addr_a, addr_b, addr_c} !== '0) begin
      failures++;
      $display("FAIL reset_values: got (%0d,%0d,%0d) a=%h b=%h c=%h, required all 0",
               idx_i, idx_j, idx_k, addr_a, addr_b, addr_c);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    int c = 1;
    bit seen = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_start(2, 2, 2, 32'h100, 32'h200, 32'h300, 1);
    while (!seen && c < 60) begin
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
          failures++;
          $display("FAIL basic_latency: got v=%b busy=%b, required 1 1", out_valid, busy);
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (c != 10) begin
          failures++;
          $display("FAIL basic_done_cycle: got %0d, required 10", c);
        end
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
          failures++;
          $display("FAIL basic_done_state: got v=%b pending=%0d, required 0 0", out_valid, sb.size());
        end
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL basic_timeout: got no done, required done");
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int c = 1, hs = 0, last_hs = 0;
    bit seen = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_start(2, 2, 2, 32'h100, 32'h200, 32'h300, 1);
    while (!seen && c < 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      out_ready = ((hs + c) % 4 == 0) || ((hs + c) % 4 == 3);
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (c != last_hs + 1 || hs != 8) begin
          failures++;
          $display("FAIL bp_done: got cycle %0d after %0d handshakes, required cycle %0d after 8", c, hs, last_hs + 1);
        end
      end else if (out_valid && out_ready) begin
        hs++;
        last_hs = c;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL bp_timeout: got no done, required done");
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bp_pending: got %0d left, required 0", sb.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_zero_dim();
    @(posedge clk); #1;
    drive_start(2, 0, 2, 32'h10, 32'h20, 32'h30, 0);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({err_zero, out_valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL zero_pulse: got err=%b v=%b busy=%b done=%b, required 1 0 0 0", err_zero, out_valid, busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({err_zero, out_valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL zero_after: got err=%b v=%b busy=%b done=%b, required 0 0 0 0", err_zero, out_valid, busy, done);
    end
  endtask

  task automatic test_single();
    int c = 1;
    bit seen = 0;
    @(posedge clk); #1;
    drive_start(1, 1, 1, 32'hABC, 32'hDEF, 32'h123, 1);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({out_valid, first_k, last_k} !== 3'b111) begin
      failures++;
      $display("FAIL single_flags: got v=%b f=%b l=%b, required 1 1 1", out_valid, first_k, last_k);
    end
    while (!seen && c < 10) begin
      @(posedge clk); #1;
      c++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || c != 2) begin
      failures++;
      $display("FAIL single_done: got seen=%b at step %0d, required seen at step 2", seen, c);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || sb.size() != 0) begin
      failures++;
      $display("FAIL single_idle: got v=%b busy=%b done=%b pending=%0d, required 0 0 0 0", out_valid, busy, done, sb.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int c = 0, hs = 0;
    bit seen = 0;
    @(posedge clk); #1;
    drive_start(3, 3, 3, 32'h40, 32'h80, 32'hC0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    while (hs < 3 && c < 20) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
      c++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || {idx_i, idx_j, idx_k} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b busy=%b done=%b (%0d,%0d,%0d), required 0 0 0 (0,0,0)",
               out_valid, busy, done, idx_i, idx_j, idx_k);
    end
    sb.delete();
    @(posedge clk); @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release: got v=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    drive_start(2, 2, 2, 32'h1000, 32'h2000, 32'h3000, 1);
    c = 0;
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || sb.size() != 0) begin
      failures++;
      $display("FAIL restart: got done=%b pending=%0d, required 1 0", seen, sb.size());
    end
  endtask

  task automatic test_start_in_run();
    int c = 0, total = 0;
    bit seen = 0;
    @(posedge clk); #1;
    drive_start(2, 1, 3, 32'h500, 32'h600, 32'h700, 1);
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (c == 3) drive_start(3, 3, 3, 32'h9000, 32'h9100, 32'h9200, 0);
      else start = 1'b0;
      if (out_valid && out_ready) total++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || total != 6 || sb.size() != 0) begin
      failures++;
      $display("FAIL start_in_run: got done=%b tuples=%0d pending=%0d, required 1 6 0", seen, total, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_single();
    test_reset_mid_run();
    test_start_in_run();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_addr_gen.md
# matmul_addr_gen

Parametrised loop-nest index and address generator for the matrix-multiply datapath. It walks C[i][j] += A[i][k]·B[k][j] in i-outer, j-middle, k-inner order. Each step it emits the (i, j, k) tuple, the three row-major element addresses, and accumulator first/last flags over a valid/ready handshake. It replaces the fixed-width, free-running index stepper with a start/done controller that supports backpressure and latched dimensions, and it computes addresses without multipliers.

## Interface

Parameters:
- IDX_W, 32, width of dimension and index values
- ADDR_W, 32, width of base and element addresses

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately, release is sampled on clk
- start  in  1  begin a run; honoured only in IDLE
- num_i, num_j, num_k  in  IDX_W each  loop bounds; latched on accepted start
- base_a, base_b, base_c  in  ADDR_W each  matrix base addresses; latched on accepted start
- out_valid  out  1  current tuple valid
- out_ready  in  1  consumer accepts tuple when out_valid && out_ready
- idx_i, idx_j, idx_k  out  IDX_W each  current indices
- addr_a  out  ADDR_W  base_a + i·num_k + k
- addr_b  out  ADDR_W  base_b + k·num_j + j
- addr_c  out  ADDR_W  base_c + i·num_j + j
- first_k  out  1  idx_k == 0 (clear accumulator)
- last_k  out  1  idx_k == num_k−1 (write back C)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final tuple is accepted
- err_zero  out  1  one-cycle pulse when start is rejected because a dimension is 0

## Operation

- States: IDLE, RUN, DONE.
- IDLE, start=1, all dims nonzero: latch dims and bases, load i=j=k=0, addr_a=base_a, addr_b=base_b, addr_c=base_c, row_a=base_a. Go to RUN.
- IDLE, start=1, any dim 0: pulse err_zero, stay in IDLE, out_valid stays 0.
- start is ignored in RUN and DONE.
- RUN: out_valid=1. An advance occurs only on a handshake. With out_ready=0, every output holds stable.
- Advance rules, each applied to the indices and addresses of the accepted tuple:
  - k < num_k−1: k+1; addr_a+1; addr_b+num_j.
  - k wraps, j < num_j−1: k=0; j+1; addr_a=row_a; addr_b=base_b+j+1; addr_c+1.
  - k and j wrap, i < num_i−1: k=j=0; i+1; row_a+=num_k; addr_a=new row_a; addr_b=base_b; addr_c+1.
  - All three at their maximum (final tuple): go to DONE; out_valid=0.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Addresses are modulo 2^ADDR_W; wrap silently.
  - num_j and num_k are zero-extended to ADDR_W before adding.
  - No multipliers are used.
- first_k and last_k are derived from the registered idx_k. A 1-deep k loop has both set on every tuple.
- Reset values: out_valid=0, busy=0, done=0, err_zero=0, all idx=0, all addr=0, first_k=1, last_k=0. State is IDLE and latched dims are 0.

## Timing

- Latency from start: the first tuple is valid on the cycle after start is sampled.
- Throughput: one tuple per cycle while out_ready=1. A run takes num_i·num_j·num_k handshakes.
- done is asserted on the cycle after the final handshake, and out_valid is already 0 on that cycle. start is accepted on the following cycle at the earliest.
- Reset asserted mid-run: outputs clear immediately and asynchronously. No done pulse is produced. After release the block is in IDLE.
- Inputs num_* and base_* are not sampled outside an accepted start. Changes during RUN have no effect.

## Test plan

- 2×2×2 run, bases A=0x100, B=0x200, C=0x300, out_ready=1 → 8 tuples:
  - (i,j,k) = (0,0,0), (0,0,1), (0,1,0), (0,1,1), (1,0,0), …
  - addr_a = 100,101,100,101,102,103,102,103
  - addr_b = 200,202,201,203,200,202,201,203
  - addr_c = 300,300,301,301,302,302,303,303
  - first_k and last_k alternate.
  - done pulses on cycle 10 after start.
- Same run with out_ready toggled 1,0,0,1,… → identical tuple sequence; outputs held while out_ready=0; done follows the 8th handshake.
- start with num_j=0 → err_zero pulses for 1 cycle; out_valid, busy and done stay 0.
- 1×1×1 run → single tuple (0,0,0) with first_k=last_k=1, then done pulse, then IDLE.
- Reset driven to 0 after 3 handshakes of a 3×3×3 run → out_valid, busy and idx clear without waiting for clk. After release, a new start restarts at (0,0,0).
- start pulsed again during RUN with different dims → ignored; the sequence completes with the original dims.
